// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-cell modulo counter: J/K opcodes and the
// load clamp used when a parallel load value lies outside the count range.
package jk_counter_pkg;

   // Encoded as {J, K}
   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_op_e;

   localparam int MAX_WIDTH = 16;

   function automatic logic [MAX_WIDTH-1:0] clamp_load(
      input logic [MAX_WIDTH-1:0] value,
      input int unsigned          modulus
   );
      if (32'(value) < modulus)
         return value;
      else
         return MAX_WIDTH'(modulus - 1);
   endfunction

   function automatic jk_op_e force_bit(input logic value);
      return value ? JK_SET : JK_RST;
   endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/data bundle of the modulo counter. The master side drives the
// controls and load value; the counter (slave) returns count, carry and flag.
interface jk_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] din;
   logic             oe;
   logic             wrap_clr;
   logic [WIDTH-1:0] dout;
   logic             tc;
   logic             wrapped;

   modport master (
      output en, up, load, din, oe, wrap_clr,
      input  dout, tc, wrapped
   );

   modport slave (
      input  en, up, load, din, oe, wrap_clr,
      output dout, tc, wrapped
   );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_cell
   import jk_counter_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qn
);

   logic q_reg;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q_reg <= 1'b0;
      end else begin
         case (jk_op_e'({j, k}))
            JK_HOLD: q_reg <= q_reg;
            JK_RST:  q_reg <= 1'b0;
            JK_SET:  q_reg <= 1'b1;
            JK_TGL:  q_reg <= ~q_reg;
         endcase
      end
   end

   assign q  = q_reg;
   assign qn = ~q_reg;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo counter built from one JK cell per bit. Each bit's J/K pair
// is derived combinationally: forced for load/wrap, toggled when counting.
module jk_mod_counter
   import jk_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   jk_mod_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qn;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] wrap_val;
   logic [WIDTH-1:0] carry_up;
   logic [WIDTH-1:0] carry_dn;
   logic [WIDTH-1:0] toggle;
   logic             at_max;
   logic             at_zero;
   logic             over_range;
   logic             wrap_sel;
   logic             tc;
   logic             wrapped_reg;

   assign at_max  = (q == MAX_VAL);
   assign at_zero = (q == '0);

   // Out-of-range states only exist when the modulus leaves codes unused
   generate
      if (MODULUS < 2 ** WIDTH) begin : g_range
         assign over_range = (q > MAX_VAL);
      end else begin : g_full
         assign over_range = 1'b0;
      end
   endgenerate

   assign wrap_sel = bus.up ? (at_max | over_range) : (at_zero | over_range);
   assign wrap_val = bus.up ? '0 : MAX_VAL;
   assign load_val = WIDTH'(clamp_load(MAX_WIDTH'(bus.din), MODULUS));

   // Ripple toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down)
   assign carry_up[0] = 1'b1;
   assign carry_dn[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_carry
         assign carry_up[gi] = carry_up[gi-1] & q[gi-1];
         assign carry_dn[gi] = carry_dn[gi-1] & qn[gi-1];
      end
   endgenerate

   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         jk_op_e op;

         assign toggle[gi] = bus.up ? carry_up[gi] : carry_dn[gi];

         always_comb begin
            op = JK_HOLD;
            if (bus.load) begin
               op = force_bit(load_val[gi]);
            end else if (bus.en) begin
               if (wrap_sel)
                  op = force_bit(wrap_val[gi]);
               else if (toggle[gi])
                  op = JK_TGL;
            end
         end

         assign {j[gi], k[gi]} = op;

         jk_cell u_cell (
            .clk (clk),
            .clr (clr),
            .j   (j[gi]),
            .k   (k[gi]),
            .q   (q[gi]),
            .qn  (qn[gi])
         );
      end
   endgenerate

   assign tc = bus.en & ~bus.load & ((bus.up & at_max) | (~bus.up & at_zero));

   // Set has priority over clear so a wrap is never lost
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         wrapped_reg <= 1'b0;
      else if (tc)
         wrapped_reg <= 1'b1;
      else if (bus.wrap_clr)
         wrapped_reg <= 1'b0;
   end

   assign bus.dout    = bus.oe ? q : '0;
   assign bus.tc      = tc;
   assign bus.wrapped = wrapped_reg;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: a default 4-bit instance driven from a
// vector table, plus a MODULUS=10 instance for down-count and clamp cases.
module tb_jk_mod_counter;

   typedef struct {
      logic       en;
      logic       up;
      logic       load;
      logic [3:0] din;
      logic       oe;
      logic       wrap_clr;
      logic [3:0] dout;
      logic       tc;
      logic       wrapped;
   } vec_t;

   logic clk;
   logic clr;
   int   checks;
   int   failures;
   vec_t vecs[$];

   jk_mod_counter_if #(.WIDTH(4)) ifa ();
   jk_mod_counter_if #(.WIDTH(4)) ifb ();

   jk_mod_counter #(.WIDTH(4)) dut_a (
      .clk (clk),
      .clr (clr),
      .bus (ifa)
   );

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
      .clk (clk),
      .clr (clr),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic up, input logic load, input logic [3:0] din,
                      input logic oe, input logic wc, input logic [3:0] dout,
                      input logic tc, input logic wr);
      vec_t v;
      v.en = en; v.up = up; v.load = load; v.din = din; v.oe = oe; v.wrap_clr = wc;
      v.dout = dout; v.tc = tc; v.wrapped = wr;
      vecs.push_back(v);
   endtask

   task automatic drive_a(input logic en, input logic up, input logic load, input logic [3:0] din,
                          input logic oe, input logic wc);
      ifa.en = en; ifa.up = up; ifa.load = load; ifa.din = din; ifa.oe = oe; ifa.wrap_clr = wc;
   endtask

   task automatic drive_b(input logic en, input logic up, input logic load, input logic [3:0] din,
                          input logic oe, input logic wc);
      ifb.en = en; ifb.up = up; ifb.load = load; ifb.din = din; ifb.oe = oe; ifb.wrap_clr = wc;
   endtask

   initial begin
      logic [3:0] ld_in [4];
      logic [3:0] ld_exp[4];
      logic [3:0] exp_b;

      checks   = 0;
      failures = 0;
      clr      = 1'b0;
      drive_a(0, 1, 0, 0, 1, 0);
      drive_b(0, 0, 0, 0, 1, 0);

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_dout_a", 32'(ifa.dout), 0);
      check("rst_wrapped_a", 32'(ifa.wrapped), 0);
      check("rst_tc_a", 32'(ifa.tc), 0);
      check("rst_tc_b_en0", 32'(ifb.tc), 0);
      drive_b(1, 0, 0, 0, 1, 0);
      #1;
      check("rst_tc_b_down", 32'(ifb.tc), 1);
      check("rst_dout_b", 32'(ifb.dout), 0);
      drive_b(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      clr = 1'b1;

      // Full wrap of the default counter
      for (int i = 0; i <= 16; i++)
         add(1, 1, 0, 0, 1, 0, 4'(i % 16), (i == 15), (i == 16));
      add(0, 1, 0, 0,  1, 1,  1, 0, 1);
      add(1, 0, 0, 0,  1, 0,  1, 0, 0);
      add(1, 0, 0, 0,  1, 0,  0, 1, 0);
      add(1, 0, 0, 0,  1, 0, 15, 0, 1);
      add(1, 1, 1, 12, 1, 0, 14, 0, 1);
      add(0, 1, 0, 0,  1, 0, 12, 0, 1);
      add(1, 1, 0, 0,  0, 0,  0, 0, 1);
      add(0, 1, 0, 0,  1, 0, 13, 0, 1);
      add(1, 1, 1, 15, 1, 0, 13, 0, 1);
      add(1, 1, 1, 3,  1, 0, 15, 0, 1);
      add(1, 0, 0, 0,  1, 0,  3, 0, 1);
      add(1, 1, 0, 0,  1, 0,  2, 0, 1);
      add(0, 0, 0, 0,  1, 0,  3, 0, 1);
      add(0, 0, 1, 0,  1, 0,  3, 0, 1);
      add(0, 0, 0, 0,  1, 0,  0, 0, 1);
      add(1, 0, 0, 0,  1, 1,  0, 1, 1);
      add(0, 0, 0, 0,  1, 1, 15, 0, 1);
      add(0, 0, 0, 0,  1, 0, 15, 0, 0);
      add(1, 1, 1, 7,  1, 0, 15, 0, 0);
      add(1, 1, 1, 12, 1, 0,  7, 0, 0);
      add(0, 1, 0, 0,  1, 0, 12, 0, 0);
      add(0, 1, 1, 3,  1, 0, 12, 0, 0);
      for (int i = 0; i < 4; i++)
         add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,  1, 0,  7, 0, 0);
      add(0, 1, 0, 0,  1, 0,  8, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive_a(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].din, vecs[i].oe, vecs[i].wrap_clr);
         #1;
         $display("vec %0d en=%0b up=%0b load=%0b din=%0d oe=%0b wc=%0b -> dout=%0d tc=%0b wrapped=%0b",
                  i, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].din, vecs[i].oe,
                  vecs[i].wrap_clr, ifa.dout, ifa.tc, ifa.wrapped);
         check($sformatf("vec%0d_dout", i), 32'(ifa.dout), 32'(vecs[i].dout));
         check($sformatf("vec%0d_tc", i), 32'(ifa.tc), 32'(vecs[i].tc));
         check($sformatf("vec%0d_wrapped", i), 32'(ifa.wrapped), 32'(vecs[i].wrapped));
      end

      // Asynchronous clear between edges, mid-count
      @(negedge clk);
      drive_a(0, 1, 1, 15, 1, 0);
      @(negedge clk);
      drive_a(1, 1, 0, 0, 1, 0);
      repeat (6) @(negedge clk);
      #1;
      $display("async_clr pre: dout=%0d wrapped=%0b", ifa.dout, ifa.wrapped);
      check("pre_clr_dout", 32'(ifa.dout), 5);
      check("pre_clr_wrapped", 32'(ifa.wrapped), 1);
      #2 clr = 1'b0;
      #1;
      $display("async_clr low: dout=%0d wrapped=%0b", ifa.dout, ifa.wrapped);
      check("async_clr_dout", 32'(ifa.dout), 0);
      check("async_clr_wrapped", 32'(ifa.wrapped), 0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      #1;
      $display("async_clr release: dout=%0d", ifa.dout);
      check("clr_resume_dout", 32'(ifa.dout), 1);

      // Wrap with simultaneous wrap_clr: set wins
      @(negedge clk);
      drive_a(0, 1, 1, 15, 1, 1);
      @(negedge clk);
      #1;
      check("wc_load_dout", 32'(ifa.dout), 15);
      check("wc_load_wrapped", 32'(ifa.wrapped), 0);
      drive_a(1, 1, 0, 0, 1, 1);
      #1;
      check("wc_tc", 32'(ifa.tc), 1);
      @(negedge clk);
      #1;
      $display("wrap+wrap_clr: dout=%0d wrapped=%0b", ifa.dout, ifa.wrapped);
      check("wc_wrap_dout", 32'(ifa.dout), 0);
      check("wc_wrap_wrapped", 32'(ifa.wrapped), 1);
      drive_a(0, 1, 0, 0, 1, 1);
      @(negedge clk);
      #1;
      $display("wrap_clr alone: wrapped=%0b", ifa.wrapped);
      check("wc_clear_wrapped", 32'(ifa.wrapped), 0);
      drive_a(0, 1, 0, 0, 1, 0);

      // MODULUS=10 down count from reset
      @(negedge clk);
      clr = 1'b0;
      drive_b(1, 0, 0, 0, 1, 0);
      @(negedge clk);
      clr = 1'b1;
      #1;
      for (int kk = 0; kk < 12; kk++) begin
         if (kk > 0) begin
            @(negedge clk);
            #1;
         end
         exp_b = 4'((10 - kk % 10) % 10);
         $display("mod10 down %0d: dout=%0d tc=%0b wrapped=%0b", kk, ifb.dout, ifb.tc, ifb.wrapped);
         check($sformatf("m10_dout%0d", kk), 32'(ifb.dout), 32'(exp_b));
         check($sformatf("m10_tc%0d", kk), 32'(ifb.tc), 32'(exp_b == 0));
         check($sformatf("m10_wrapped%0d", kk), 32'(ifb.wrapped), 32'(kk >= 1));
      end

      // MODULUS=10 load clamp
      ld_in  = '{4'd13, 4'd7, 4'd10, 4'd15};
      ld_exp = '{4'd9,  4'd7, 4'd9,  4'd9};
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         drive_b(1, 1, 1, ld_in[n], 1, 0);
         @(negedge clk);
         #1;
         $display("mod10 load din=%0d: dout=%0d", ld_in[n], ifb.dout);
         check($sformatf("m10_load%0d", ld_in[n]), 32'(ifb.dout), 32'(ld_exp[n]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jk_mod_counter.md
JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal 2..16).
REQ-002 Parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (legal 2..2**WIDTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 din  input  WIDTH  load value.
REQ-009 oe  input  1  output enable for dout.
REQ-010 dout  output  WIDTH  count value, gated by oe.
REQ-011 tc  output  1  terminal-count / cascade carry, combinational.
REQ-012 wrapped  output  1  sticky wrap flag, registered.
REQ-013 wrap_clr  input  1  synchronous clear of wrapped.

Function
REQ-014 Internal count q SHALL be held in WIDTH JK cells, one per bit; no behavioural adder SHALL drive q.
REQ-015 Per-edge priority SHALL be load > en > hold.
REQ-016 load=1: q <= din if din < MODULUS, else q <= MODULUS-1; bit cells driven J=din_i, K=~din_i (or clamped value).
REQ-017 load=0, en=1, up=1: q <= q+1; if q == MODULUS-1, q <= 0.
REQ-018 load=0, en=1, up=0: q <= q-1; if q == 0, q <= MODULUS-1.
REQ-019 Counting SHALL use J=K=toggle_i per bit; the wrap case SHALL force J/K to produce the wrap value in the same single edge.
REQ-020 load=0, en=0: all cells J=K=0, q holds.
REQ-021 If q ever holds a value >= MODULUS (not reachable by construction), next counting edge SHALL go to 0 when up, MODULUS-1 when down.
REQ-022 tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)), same cycle, no latency.
REQ-023 wrapped SHALL set on the edge where tc=1; wrap_clr clears it; simultaneous tc and wrap_clr SHALL leave wrapped=1 (set wins).
REQ-024 dout = q when oe=1, all-zero when oe=0; oe SHALL NOT affect q, tc or wrapped.
REQ-025 Direction change takes effect on the same edge up is sampled; no pipeline between inputs and q.
REQ-026 Count latency: dout reflects a load or count step one clock after the sampling edge.

Reset
REQ-027 clr=0 SHALL immediately, without a clock edge, force q=0 and wrapped=0.
REQ-028 During reset dout=0 and tc evaluates on q=0 (may assert when en=1, up=0).
REQ-029 Reset deassertion SHALL be honoured at the next rising edge; no operation is lost other than those during clr=0.
REQ-030 Reset mid-count SHALL abandon the current count; no state survives.

Structure
REQ-031 Shared package jk_counter_pkg SHALL hold JK opcode constants (JK_HOLD=00, JK_RST=01, JK_SET=10, JK_TGL=11) and the clamp function used by REQ-016.
REQ-032 One sub-module jk_cell: single JK flip-flop with asynchronous active-low clr, ports clk, clr, j, k, q, qn.
REQ-033 Toggle/load/wrap J/K derivation SHALL be combinational logic in jk_mod_counter, generated per bit over WIDTH.

Verification
REQ-034 Defaults, en=1 up=1 oe=1, 17 clocks from reset -> dout 0,1..15,0; tc=1 only while q=15; wrapped=1 after the 16th edge.
REQ-035 MODULUS=10, en=1 up=0 from reset -> dout 9,8..0,9; tc=1 at q=0 both before first edge and at q=0 later.
REQ-036 Defaults, q=7, load=1 din=12 with en=1 -> dout=12 next cycle; MODULUS=10, din=13 -> dout=9.
REQ-037 Defaults, count to 5, assert clr low between clock edges -> dout=0 and wrapped=0 before next edge; counting resumes 1 after release.
REQ-038 q=15 up en=1 with wrap_clr=1 on same edge -> q=0, wrapped=1; wrap_clr next cycle with tc=0 -> wrapped=0.
REQ-039 oe toggled 0 during count 3..6 -> dout=0 for those cycles, dout=7 on re-enable; tc and q sequence unchanged.
